// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART Tx-side blocks (and the future Rx scheduler).
//   arb_state_t : arbiter FSM states IDLE / START / BUSY
//   UART_DATA_W : width of one UART data byte
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if
// Requester-side valid/ready bundle for the UART Tx arbiter.
//   req_valid[N]        : requester i offers a byte
//   req_data[N*8]       : byte i sits at bits [8i+7:8i]
//   req_ready[N]        : one-hot acceptance from the arbiter
// Modports: master = client logic, slave = arbiter.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int N = 4
);
  logic [N-1:0]             req_valid;
  logic [N*UART_DATA_W-1:0] req_data;
  logic [N-1:0]             req_ready;

  modport master (output req_valid, output req_data, input req_ready);
  modport slave  (input req_valid, input req_data, output req_ready);
endinterface

// File: rtl/uart_rr_pick.sv
// uart_rr_pick
// Combinational round-robin picker: first set bit of req_valid at or above
// ptr, wrapping modulo N.
//   req_valid[N] : request vector
//   ptr          : index with highest priority this cycle (always < N)
//   grant[N]     : one-hot winner, all-zero when nothing is valid
//   winner       : binary index of the winner (0 when nothing is valid)
//   any_valid    : at least one request is valid
module uart_rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] winner,
  output logic          any_valid
);

  int idx;

  always_comb begin
    grant     = '0;
    winner    = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      // Explicit wrap rather than a power-of-2 mask so any N in 2..16 works.
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!any_valid && req_valid[idx]) begin
        any_valid   = 1'b1;
        winner      = IW'(idx);
        grant[idx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmitter among N byte requesters with round-robin
// fairness. One byte is accepted in IDLE, Tx_start pulses during START, and
// the byte plus its grant index are held until Tx_done arrives in BUSY.
// Ports:
//   clk, resetn       : clock, asynchronous active-low reset
//   req_if (slave)    : req_valid / req_data / req_ready requester bundle
//   Tx_start          : one-cycle registered start strobe
//   Tx_d_in[8]        : registered byte, stable through START and BUSY
//   Tx_done           : transmitter finished the frame (ignored in START)
//   grant_id          : index of the requester being served
//   busy              : registered, high in START and BUSY
//   timeout_err       : one-cycle pulse when a frame is aborted
// Optional feature: define UART_TX_ARB_TIMEOUT_EN to abort a frame that sees
// no Tx_done within TIMEOUT BUSY cycles; otherwise BUSY waits forever and
// timeout_err is tied low.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int N       = 4,
  parameter  int TIMEOUT = 4096,
  localparam int IW      = $clog2(N)
) (
  input  logic                   clk,
  input  logic                   resetn,
  uart_tx_arbiter_if.slave       req_if,
  output logic                   Tx_start,
  output logic [UART_DATA_W-1:0] Tx_d_in,
  input  logic                   Tx_done,
  output logic [IW-1:0]          grant_id,
  output logic                   busy,
  output logic                   timeout_err
);

  arb_state_t             state_q, state_d;
  logic [IW-1:0]          ptr_q, ptr_d;
  logic [IW-1:0]          grant_q, grant_d;
  logic [UART_DATA_W-1:0] data_q, data_d;
  logic                   start_q, start_d;
  logic                   busy_q, busy_d;

  logic [N-1:0]           pick_grant;
  logic [IW-1:0]          pick_idx;
  logic                   pick_any;
  logic [UART_DATA_W-1:0] req_bytes [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign req_bytes[gi] = req_if.req_data[UART_DATA_W*gi +: UART_DATA_W];
  end

  uart_rr_pick #(.N(N)) u_pick (
    .req_valid (req_if.req_valid),
    .ptr       (ptr_q),
    .grant     (pick_grant),
    .winner    (pick_idx),
    .any_valid (pick_any)
  );

  // Ready only in IDLE; gating with resetn keeps it low during reset even
  // though the state register already reads IDLE.
  assign req_if.req_ready = (state_q == IDLE && resetn) ? pick_grant : '0;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          terr_q, terr_d;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    data_d  = data_q;
    start_d = 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    terr_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = START;
          data_d  = req_bytes[pick_idx];
          grant_d = pick_idx;
          ptr_d   = (pick_idx == IW'(N - 1)) ? '0 : pick_idx + IW'(1);
          start_d = 1'b1;
        end
      end
      START: begin
        state_d = BUSY;
`ifdef UART_TX_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      BUSY: begin
        // Tx_done wins over a coinciding expiry.
        if (Tx_done) begin
          state_d = IDLE;
`ifdef UART_TX_ARB_TIMEOUT_EN
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = IDLE;
          terr_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + CW'(1);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      terr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      start_q <= start_d;
      busy_q  <= busy_d;
`ifdef UART_TX_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
`endif
    end
  end

  assign Tx_start = start_q;
  assign Tx_d_in  = data_q;
  assign grant_id = grant_q;
  assign busy     = busy_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter with N=4, TIMEOUT=16. Covers reset
// values, single requester, full contention with pointer wrap, pointer
// fairness, reset mid-frame, and the BUSY timeout behaviour for whichever
// build (UART_TX_ARB_TIMEOUT_EN defined or not) is compiled.
module tb_uart_tx_arbiter;

  logic       clk;
  logic       resetn;
  logic       Tx_start;
  logic [7:0] Tx_d_in;
  logic       Tx_done;
  logic [1:0] grant_id;
  logic       busy;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter_if #(.N(4)) req_if ();

  uart_tx_arbiter #(.N(4), .TIMEOUT(16)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .req_if      (req_if),
    .Tx_start    (Tx_start),
    .Tx_d_in     (Tx_d_in),
    .Tx_done     (Tx_done),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One complete frame: acceptance, START, BUSY for busy_cycles+1 cycles
  // (Tx_done raised in the last one), back to IDLE.
  task automatic do_frame(input logic [3:0] valid, input int exp_g,
                          input logic [7:0] exp_b, input int busy_cycles);
    req_if.req_valid = valid;
    #1;
    chk("ready_idle", req_if.req_ready, 32'(4'b0001 << exp_g));
    chk("start_before", Tx_start, 0);
    tick();
    chk("start_pulse", Tx_start, 1);
    chk("d_in", Tx_d_in, exp_b);
    chk("grant_id", grant_id, exp_g);
    chk("busy_start", busy, 1);
    chk("ready_start", req_if.req_ready, 0);
    tick();
    for (int i = 0; i < busy_cycles; i++) begin
      chk("no_start_busy", Tx_start, 0);
      chk("hold_d_in", Tx_d_in, exp_b);
      chk("hold_grant", grant_id, exp_g);
      chk("busy_busy", busy, 1);
      tick();
    end
    chk("no_start_done", Tx_start, 0);
    Tx_done = 1'b1;
    tick();
    Tx_done = 1'b0;
    chk("busy_after_done", busy, 0);
    $display("frame grant=%0d byte=%02h", exp_g, exp_b);
  endtask

  initial begin
    resetn           = 1'b0;
    Tx_done          = 1'b0;
    req_if.req_valid = 4'b1111;
    req_if.req_data  = '0;
    tick();
    tick();

    // Reset values, with requests present to show ready is gated.
    chk("rst_start", Tx_start, 0);
    chk("rst_d_in", Tx_d_in, 8'h00);
    chk("rst_grant", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_ready", req_if.req_ready, 0);
    req_if.req_valid = 4'b0000;
    resetn           = 1'b1;
    tick();

    // Single requester 2 with A5.
    req_if.req_data = 32'h00A5_0000;
    do_frame(4'b0100, 2, 8'hA5, 3);
    req_if.req_valid = 4'b0000;
    tick();

    // Reset mid-frame: requester 1 (ptr=3 -> search 3,0,1), pulsed in BUSY.
    req_if.req_data  = 32'h0000_5500;
    req_if.req_valid = 4'b0010;
    tick();
    chk("mid_start", Tx_start, 1);
    chk("mid_grant", grant_id, 1);
    tick();
    tick();
    chk("mid_busy", busy, 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_rst_start", Tx_start, 0);
    chk("mid_rst_d_in", Tx_d_in, 8'h00);
    chk("mid_rst_grant", grant_id, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_terr", timeout_err, 0);
    chk("mid_rst_ready", req_if.req_ready, 0);
    req_if.req_valid = 4'b0000;
    tick();
    resetn = 1'b1;
    tick();

    // Full contention: ptr restarts at 0, order 10,11,12,13,10 (wrap 3->0).
    req_if.req_data = 32'h1312_1110;
    do_frame(4'b1111, 0, 8'h10, 2);
    do_frame(4'b1111, 1, 8'h11, 2);
    do_frame(4'b1111, 2, 8'h12, 2);
    do_frame(4'b1111, 3, 8'h13, 2);
    do_frame(4'b1111, 0, 8'h10, 2);

    // Fairness: grant 1, then with 0 and 3 valid, 3 goes before 0.
    do_frame(4'b0010, 1, 8'h11, 0);
    do_frame(4'b1001, 3, 8'h13, 1);
    do_frame(4'b1001, 0, 8'h10, 1);
    req_if.req_valid = 4'b0000;
    tick();

    // Timeout scenario: requester 2 (ptr=1), Tx_done never driven.
    req_if.req_valid = 4'b0100;
    #1;
    chk("to_ready", req_if.req_ready, 4'b0100);
    tick();
    req_if.req_valid = 4'b0000;
    chk("to_start", Tx_start, 1);
    chk("to_grant", grant_id, 2);
    tick();
`ifdef UART_TX_ARB_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      chk("to_busy_wait", busy, 1);
      chk("to_terr_wait", timeout_err, 0);
      tick();
    end
    chk("to_terr_pulse", timeout_err, 1);
    chk("to_busy_idle", busy, 0);
    tick();
    chk("to_terr_one_cycle", timeout_err, 0);
    chk("to_busy_stays_idle", busy, 0);
`else
    for (int i = 0; i < 20; i++) begin
      chk("nto_busy", busy, 1);
      chk("nto_terr", timeout_err, 0);
      chk("nto_start", Tx_start, 0);
      tick();
    end
    Tx_done = 1'b1;
    tick();
    Tx_done = 1'b0;
    chk("nto_done_idle", busy, 0);
    chk("nto_terr_end", timeout_err, 0);
`endif
    $display("frame grant=2 byte=12 (no Tx_done)");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
